// File: rtl/dma_address_generator_if.sv
// Bus/handshake bundle for dma_address_generator.
// The master modport is the CPU/priority-logic side; the slave modport is the generator.
interface dma_address_generator_if #(
  parameter int NUM_CH = 4
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // CPU programming path
  logic              prog_wr;
  logic [CHW-1:0]    prog_ch;
  logic              prog_sel;
  logic [7:0]        prog_data;
  logic              ff_clear;

  // Per-channel mode bits
  logic [NUM_CH-1:0] mode_dec;
  logic [NUM_CH-1:0] mode_autoinit;
  logic [NUM_CH-1:0] mode_hold;

  // Service handshake from priority/timing logic
  logic              svc_start;
  logic [CHW-1:0]    svc_ch;
  logic              step;
  logic              svc_end;

  // System-bus side
  logic              AEN;
  logic              ADSTB;
  logic [7:0]        addr_lo;
  logic [7:0]        db_out;
  logic              db_oe;
  logic              tc;
  logic [CHW-1:0]    active_ch;

  modport master (
    output prog_wr, prog_ch, prog_sel, prog_data, ff_clear,
    output mode_dec, mode_autoinit, mode_hold,
    output svc_start, svc_ch, step, svc_end,
    input  AEN, ADSTB, addr_lo, db_out, db_oe, tc, active_ch
  );

  modport slave (
    input  prog_wr, prog_ch, prog_sel, prog_data, ff_clear,
    input  mode_dec, mode_autoinit, mode_hold,
    input  svc_start, svc_ch, step, svc_end,
    output AEN, ADSTB, addr_lo, db_out, db_oe, tc, active_ch
  );
endinterface

// File: rtl/dma_address_generator.sv
// 8237A-style per-channel address/word-count register file and transfer sequencer.
// Drives AEN/ADSTB/A7-A0 and puts the upper address byte on the data bus only
// when the external latch has to be (re)loaded.
// Optional feature macro: ADDR_HOLD_EN -- when defined, mode_hold freezes the
// active channel's address on each transfer (count still runs, auto-init still reloads).
module dma_address_generator #(
  parameter int NUM_CH = 4,
  parameter int AW     = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dma_address_generator_if.slave bus
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [CHW-1:0] active_reg, active_next;
  logic           ff_reg, ff_next;

  // Current registers of every channel, flattened so the active one can be muxed out
  logic [NUM_CH-1:0][AW-1:0] cur_addr_all;
  logic [NUM_CH-1:0][AW-1:0] cur_cnt_all;

  logic [AW-1:0] act_addr, act_cnt, step_addr, new_addr;
  logic          hold, upd, term, reload, restrobe;

  // Write one byte of a 16-bit register; hi selects the upper byte
  function automatic logic [AW-1:0] merge_byte(input logic [AW-1:0] old,
                                               input logic [7:0]    data,
                                               input logic          hi);
    logic [AW-1:0] v;
    v = old;
    if (hi) v[AW-1:AW-8] = data;
    else    v[7:0]       = data;
    return v;
  endfunction

`ifdef ADDR_HOLD_EN
  assign hold = bus.mode_hold[active_reg];
`else
  logic unused_hold;
  assign hold        = 1'b0;
  assign unused_hold = ^bus.mode_hold;
`endif

  // Active channel's registers and the result of a transfer step on them
  always_comb begin
    act_addr  = cur_addr_all[active_reg];
    act_cnt   = cur_cnt_all[active_reg];
    step_addr = bus.mode_dec[active_reg] ? (act_addr - AW'(1)) : (act_addr + AW'(1));
    new_addr  = hold ? act_addr : step_addr;
    upd       = (state_reg == XFER) && bus.step;
    term      = (act_cnt == '0);
    reload    = term && bus.mode_autoinit[active_reg];
    restrobe  = (new_addr[AW-1:AW-8] != act_addr[AW-1:AW-8]);
  end

  // Per-channel base/current registers: CPU writes, plus step update on the active channel
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [AW-1:0] base_addr_reg, base_cnt_reg, cur_addr_reg, cur_cnt_reg;
    logic          wr_hit, wr_cur, upd_hit;

    assign wr_hit  = bus.prog_wr && (bus.prog_ch == CHW'(gi));
    // The channel being serviced keeps its working registers; only base is reprogrammable
    assign wr_cur  = wr_hit && !((state_reg != IDLE) && (active_reg == CHW'(gi)));
    assign upd_hit = upd && (active_reg == CHW'(gi));

    // Register file update for channel gi
    always_ff @(posedge CLK) begin
      if (RESET) begin
        base_addr_reg <= '0;
        base_cnt_reg  <= '0;
        cur_addr_reg  <= '0;
        cur_cnt_reg   <= '0;
      end else begin
        if (wr_hit && !bus.prog_sel) base_addr_reg <= merge_byte(base_addr_reg, bus.prog_data, ff_reg);
        if (wr_hit &&  bus.prog_sel) base_cnt_reg  <= merge_byte(base_cnt_reg,  bus.prog_data, ff_reg);
        if (upd_hit) begin
          if (reload) begin
            cur_addr_reg <= base_addr_reg;
            cur_cnt_reg  <= base_cnt_reg;
          end else begin
            cur_addr_reg <= new_addr;
            cur_cnt_reg  <= cur_cnt_reg - AW'(1);
          end
        end else begin
          if (wr_cur && !bus.prog_sel) cur_addr_reg <= merge_byte(cur_addr_reg, bus.prog_data, ff_reg);
          if (wr_cur &&  bus.prog_sel) cur_cnt_reg  <= merge_byte(cur_cnt_reg,  bus.prog_data, ff_reg);
        end
      end
    end

    assign cur_addr_all[gi] = cur_addr_reg;
    assign cur_cnt_all[gi]  = cur_cnt_reg;
  end

  // State, active channel and byte-pointer registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      active_reg <= '0;
      ff_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= active_next;
      ff_reg     <= ff_next;
    end
  end

  // Next-state logic; the byte pointer toggles per write and clear wins over the toggle
  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    ff_next     = bus.ff_clear ? 1'b0 : (bus.prog_wr ? ~ff_reg : ff_reg);
    case (state_reg)
      IDLE: begin
        if (bus.svc_start) begin
          active_next = bus.svc_ch;
          state_next  = STB;
        end
      end
      STB:  state_next = XFER;
      XFER: begin
        if (bus.step) begin
          if (term || bus.svc_end) state_next = IDLE;
          else if (restrobe)       state_next = STB;
        end else if (bus.svc_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs decoded from state; tc marks the terminal step itself
  always_comb begin
    bus.AEN     = 1'b0;
    bus.ADSTB   = 1'b0;
    bus.db_oe   = 1'b0;
    bus.db_out  = '0;
    bus.addr_lo = '0;
    case (state_reg)
      STB: begin
        bus.AEN     = 1'b1;
        bus.ADSTB   = 1'b1;
        bus.db_oe   = 1'b1;
        bus.db_out  = act_addr[AW-1:AW-8];
        bus.addr_lo = act_addr[7:0];
      end
      XFER: begin
        bus.AEN     = 1'b1;
        bus.addr_lo = act_addr[7:0];
      end
      default: ;
    endcase
    bus.tc = upd && term && !RESET;
  end

  assign bus.active_ch = active_reg;

endmodule

// File: tb/tb_dma_address_generator.sv
// Self-checking bench for dma_address_generator.
// ADSTB and tc events are predicted into a queue when stimulus is driven and
// popped/compared when the generator produces them; state checks are inline.
module tb_dma_address_generator;
  localparam int NUM_CH = 4;
  localparam int CHW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_address_generator_if #(.NUM_CH(NUM_CH)) bus ();

  dma_address_generator #(.NUM_CH(NUM_CH), .AW(16)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic       is_tc;
    logic [7:0] hi;   // db_out for a strobe, channel number for tc
    logic [7:0] lo;   // addr_lo seen with the event
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input logic is_tc, input logic [7:0] hi, input logic [7:0] lo);
    ev_t e;
    e.is_tc = is_tc;
    e.hi    = hi;
    e.lo    = lo;
    return e;
  endfunction

  // One clock: compare any strobe/tc event at the falling edge, then advance
  task automatic cycle();
    ev_t e;
    @(negedge clk);
    if (bus.ADSTB === 1'b1 || bus.tc === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected adstb=%0b tc=%0b db_out=%02h addr_lo=%02h, none expected",
                 bus.ADSTB, bus.tc, bus.db_out, bus.addr_lo);
      end else begin
        e = exp_q.pop_front();
        if (e.is_tc) begin
          if (bus.tc !== 1'b1 || bus.ADSTB !== 1'b0 || bus.addr_lo !== e.lo ||
              bus.active_ch !== e.hi[CHW-1:0]) begin
            errors++;
            $display("FAIL sb_tc got tc=%0b adstb=%0b ch=%0d addr_lo=%02h expected tc=1 ch=%0d addr_lo=%02h",
                     bus.tc, bus.ADSTB, bus.active_ch, bus.addr_lo, e.hi, e.lo);
          end
        end else begin
          if (bus.ADSTB !== 1'b1 || bus.AEN !== 1'b1 || bus.db_oe !== 1'b1 || bus.tc !== 1'b0 ||
              bus.db_out !== e.hi || bus.addr_lo !== e.lo) begin
            errors++;
            $display("FAIL sb_adstb got adstb=%0b aen=%0b oe=%0b tc=%0b db_out=%02h addr_lo=%02h expected strobe db_out=%02h addr_lo=%02h",
                     bus.ADSTB, bus.AEN, bus.db_oe, bus.tc, bus.db_out, bus.addr_lo, e.hi, e.lo);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic prog_byte(input int ch, input logic sel, input logic [7:0] data, input logic clr);
    bus.prog_wr   = 1'b1;
    bus.prog_ch   = CHW'(ch);
    bus.prog_sel  = sel;
    bus.prog_data = data;
    bus.ff_clear  = clr;
    cycle();
    bus.prog_wr   = 1'b0;
    bus.ff_clear  = 1'b0;
  endtask

  task automatic clear_ff();
    bus.ff_clear = 1'b1;
    cycle();
    bus.ff_clear = 1'b0;
  endtask

  task automatic prog_reg(input int ch, input logic sel, input logic [15:0] val);
    clear_ff();
    prog_byte(ch, sel, val[7:0], 1'b0);
    prog_byte(ch, sel, val[15:8], 1'b0);
  endtask

  // Grant a channel, expect its strobe, and leave the generator in XFER
  task automatic start_svc(input int ch, input logic [7:0] hi, input logic [7:0] lo);
    bus.svc_start = 1'b1;
    bus.svc_ch    = CHW'(ch);
    exp_q.push_back(mk(1'b0, hi, lo));
    cycle();
    bus.svc_start = 1'b0;
    cycle();
  endtask

  task automatic do_step(input logic exp_tc, input int ch, input logic [7:0] lo_now);
    bus.step = 1'b1;
    if (exp_tc) exp_q.push_back(mk(1'b1, 8'(ch), lo_now));
    cycle();
    bus.step = 1'b0;
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    bus.prog_wr       = 1'b0;
    bus.prog_ch       = '0;
    bus.prog_sel      = 1'b0;
    bus.prog_data     = '0;
    bus.ff_clear      = 1'b0;
    bus.mode_dec      = '0;
    bus.mode_autoinit = '0;
    bus.mode_hold     = '0;
    bus.svc_start     = 1'b0;
    bus.svc_ch        = '0;
    bus.step          = 1'b0;
    bus.svc_end       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.AEN, bus.ADSTB, bus.db_oe, bus.tc} !== 4'b0 || bus.addr_lo !== 8'h00 ||
        bus.db_out !== 8'h00 || bus.active_ch !== '0) begin
      errors++;
      $display("FAIL reset_outputs aen=%0b adstb=%0b oe=%0b tc=%0b lo=%02h db=%02h ch=%0d expected all zero",
               bus.AEN, bus.ADSTB, bus.db_oe, bus.tc, bus.addr_lo, bus.db_out, bus.active_ch);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (bus.AEN !== 1'b0 || bus.db_oe !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset aen=%0b oe=%0b expected 0 0", bus.AEN, bus.db_oe);
    end
  endtask

  task automatic test_basic_increment();
    prog_reg(1, 1'b0, 16'h1234);
    prog_reg(1, 1'b1, 16'h0002);
    start_svc(1, 8'h12, 8'h34);
    checks++;
    if (bus.AEN !== 1'b1 || bus.ADSTB !== 1'b0 || bus.db_oe !== 1'b0 || bus.active_ch !== 2'd1) begin
      errors++;
      $display("FAIL xfer_outputs aen=%0b adstb=%0b oe=%0b ch=%0d expected 1 0 0 1",
               bus.AEN, bus.ADSTB, bus.db_oe, bus.active_ch);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.addr_lo !== 8'(8'h34 + i)) begin
        errors++;
        $display("FAIL inc_addr_lo step %0d got %02h expected %02h", i, bus.addr_lo, 8'(8'h34 + i));
      end
      do_step(i == 2, 1, 8'(8'h34 + i));
    end
    checks++;
    if (bus.AEN !== 1'b0 || bus.addr_lo !== 8'h00) begin
      errors++;
      $display("FAIL inc_end aen=%0b addr_lo=%02h expected 0 00", bus.AEN, bus.addr_lo);
    end
  endtask

  task automatic test_restrobe();
    prog_reg(0, 1'b0, 16'h12FF);
    prog_reg(0, 1'b1, 16'h0001);
    start_svc(0, 8'h12, 8'hFF);
    checks++;
    if (bus.addr_lo !== 8'hFF) begin
      errors++;
      $display("FAIL restrobe_first got %02h expected ff", bus.addr_lo);
    end
    exp_q.push_back(mk(1'b0, 8'h13, 8'h00));
    do_step(1'b0, 0, 8'hFF);
    cycle();
    checks++;
    if (bus.AEN !== 1'b1 || bus.addr_lo !== 8'h00) begin
      errors++;
      $display("FAIL restrobe_xfer aen=%0b addr_lo=%02h expected 1 00", bus.AEN, bus.addr_lo);
    end
    do_step(1'b1, 0, 8'h00);
    checks++;
    if (bus.AEN !== 1'b0) begin
      errors++;
      $display("FAIL restrobe_end aen=%0b expected 0", bus.AEN);
    end
  endtask

  task automatic test_dec_autoinit();
    bus.mode_dec      = 4'b0100;
    bus.mode_autoinit = 4'b0100;
    prog_reg(2, 1'b0, 16'h0000);
    prog_reg(2, 1'b1, 16'h0000);
    start_svc(2, 8'h00, 8'h00);
    do_step(1'b1, 2, 8'h00);
    checks++;
    if (bus.AEN !== 1'b0) begin
      errors++;
      $display("FAIL autoinit_end aen=%0b expected 0", bus.AEN);
    end
    // Reloaded to 0000/0000: strobe shows 00/00 and the single step terminates again
    start_svc(2, 8'h00, 8'h00);
    do_step(1'b1, 2, 8'h00);
    bus.mode_autoinit = 4'b0000;
    start_svc(2, 8'h00, 8'h00);
    do_step(1'b1, 2, 8'h00);
    // Without reload address and count wrap to FFFF
    start_svc(2, 8'hFF, 8'hFF);
    do_step(1'b0, 2, 8'hFF);
    checks++;
    if (bus.AEN !== 1'b1 || bus.addr_lo !== 8'hFE) begin
      errors++;
      $display("FAIL dec_wrap aen=%0b addr_lo=%02h expected 1 fe", bus.AEN, bus.addr_lo);
    end
    bus.svc_end = 1'b1;
    cycle();
    bus.svc_end  = 1'b0;
    bus.mode_dec = 4'b0000;
    checks++;
    if (bus.AEN !== 1'b0) begin
      errors++;
      $display("FAIL dec_svc_end aen=%0b expected 0", bus.AEN);
    end
  endtask

  task automatic test_byte_pointer();
    clear_ff();
    prog_byte(3, 1'b0, 8'hAA, 1'b0);
    clear_ff();
    prog_byte(3, 1'b0, 8'hBB, 1'b0);
    prog_reg(3, 1'b1, 16'h0000);
    start_svc(3, 8'h00, 8'hBB);
    do_step(1'b1, 3, 8'hBB);
    // Same-cycle clear: the write lands in the high byte, the next one in the low byte
    clear_ff();
    prog_byte(3, 1'b0, 8'h11, 1'b0);
    prog_byte(3, 1'b0, 8'h22, 1'b1);
    prog_byte(3, 1'b0, 8'h33, 1'b0);
    prog_reg(3, 1'b1, 16'h0000);
    start_svc(3, 8'h22, 8'h33);
    do_step(1'b1, 3, 8'h33);
  endtask

  task automatic test_end_and_ignore();
    prog_reg(1, 1'b0, 16'h0040);
    prog_reg(1, 1'b1, 16'h0005);
    start_svc(1, 8'h00, 8'h40);
    bus.svc_start = 1'b1;
    bus.svc_ch    = 2'd2;
    cycle();
    bus.svc_start = 1'b0;
    checks++;
    if (bus.active_ch !== 2'd1 || bus.AEN !== 1'b1 || bus.ADSTB !== 1'b0 || bus.addr_lo !== 8'h40) begin
      errors++;
      $display("FAIL svc_start_ignored ch=%0d aen=%0b adstb=%0b lo=%02h expected 1 1 0 40",
               bus.active_ch, bus.AEN, bus.ADSTB, bus.addr_lo);
    end
    prog_reg(1, 1'b0, 16'h7777);
    checks++;
    if (bus.addr_lo !== 8'h40 || bus.AEN !== 1'b1) begin
      errors++;
      $display("FAIL cur_protected addr_lo=%02h aen=%0b expected 40 1", bus.addr_lo, bus.AEN);
    end
    bus.step    = 1'b1;
    bus.svc_end = 1'b1;
    cycle();
    bus.step    = 1'b0;
    bus.svc_end = 1'b0;
    checks++;
    if (bus.AEN !== 1'b0) begin
      errors++;
      $display("FAIL step_svc_end aen=%0b expected 0", bus.AEN);
    end
    start_svc(1, 8'h00, 8'h41);
    bus.svc_end = 1'b1;
    cycle();
    bus.svc_end = 1'b0;
    start_svc(1, 8'h00, 8'h41);
    bus.svc_end = 1'b1;
    cycle();
    bus.svc_end = 1'b0;
  endtask

  task automatic test_abort_reset();
    prog_reg(2, 1'b0, 16'h5678);
    prog_reg(2, 1'b1, 16'h0000);
    start_svc(2, 8'h56, 8'h78);
    rst      = 1'b1;
    bus.step = 1'b1;
    cycle();
    bus.step = 1'b0;
    checks++;
    if ({bus.AEN, bus.ADSTB, bus.db_oe, bus.tc} !== 4'b0 || bus.addr_lo !== 8'h00 ||
        bus.db_out !== 8'h00 || bus.active_ch !== '0) begin
      errors++;
      $display("FAIL abort_outputs aen=%0b adstb=%0b oe=%0b tc=%0b lo=%02h db=%02h ch=%0d expected all zero",
               bus.AEN, bus.ADSTB, bus.db_oe, bus.tc, bus.addr_lo, bus.db_out, bus.active_ch);
    end
    rst = 1'b0;
    cycle();
    start_svc(2, 8'h00, 8'h00);
    do_step(1'b1, 2, 8'h00);
  endtask

  task automatic test_hold();
    bus.mode_hold = 4'b0010;
    prog_reg(1, 1'b0, 16'h10FF);
    prog_reg(1, 1'b1, 16'h0002);
    start_svc(1, 8'h10, 8'hFF);
`ifdef ADDR_HOLD_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.addr_lo !== 8'hFF) begin
        errors++;
        $display("FAIL hold_addr step %0d got %02h expected ff", i, bus.addr_lo);
      end
      do_step(i == 2, 1, 8'hFF);
    end
`else
    exp_q.push_back(mk(1'b0, 8'h11, 8'h00));
    do_step(1'b0, 1, 8'hFF);
    cycle();
    checks++;
    if (bus.addr_lo !== 8'h00) begin
      errors++;
      $display("FAIL hold_ignored got %02h expected 00", bus.addr_lo);
    end
    do_step(1'b0, 1, 8'h00);
    do_step(1'b1, 1, 8'h01);
`endif
    bus.mode_hold = 4'b0000;
    checks++;
    if (bus.AEN !== 1'b0) begin
      errors++;
      $display("FAIL hold_end aen=%0b expected 0", bus.AEN);
    end
  endtask

  initial begin
    test_reset();
    test_basic_increment();
    test_restrobe();
    test_dec_autoinit();
    test_byte_pointer();
    test_end_and_ignore();
    test_abort_reset();
    test_hold();
    repeat (2) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover %0d expected events never seen, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "time limit reached");
  end

endmodule
